// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
//
// Instruction-decode stage with an integrated ID/EX pipeline register.
//
// The stage decodes a 32-bit MIPS-style instruction through the Controller
// table. It reads two operands from a REG_NUM x DATA_W register file, and a
// write-back bypass can forward same-cycle write data to the read ports. The
// stage extends the 16-bit immediate and selects operand 2. Operand 2 is the
// immediate for I-type instructions and rd2 for everything else. Load-use
// hazards against the EXE stage are detected here. The decoded bundle is held
// in an output register under a valid/ready handshake, with flush support and
// a saturating stall counter.
//
// Ports
//   clk, rst           : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  : instruction handshake from IF (in_ready is combinational)
//   instr_in           : 32-bit instruction
//   flush              : drop the held bundle and the current input
//   wb_en/addr/data    : register-file write port (write-back stage)
//   exe_valid, exe_mem_r_en, exe_dest : EXE-stage info for load-use detection
//   out_valid/out_ready: output handshake toward EXE
//   out_*              : registered decode bundle
//   stall_cnt          : saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_NUM    = 32,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int IMM_SIGNED = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr_in,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              exe_valid,
    input  logic              exe_mem_r_en,
    input  logic [4:0]        exe_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic [1:0]        out_br_type,
    output logic [3:0]        out_exe_cmd,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_data2,
    output logic [4:0]        out_dest,
    output logic [31:0]       out_instr,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Opcodes understood by the Controller (instr[31:26]).
    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    // EXE_Cmd encodings.
    localparam logic [3:0] EXE_ADD = 4'b0000;
    localparam logic [3:0] EXE_SUB = 4'b0010;
    localparam logic [3:0] EXE_AND = 4'b0100;
    localparam logic [3:0] EXE_OR  = 4'b0101;
    localparam logic [3:0] EXE_NOR = 4'b0110;
    localparam logic [3:0] EXE_XOR = 4'b0111;
    localparam logic [3:0] EXE_SLA = 4'b1000;
    localparam logic [3:0] EXE_SRA = 4'b1001;
    localparam logic [3:0] EXE_SRL = 4'b1010;
    localparam logic [3:0] EXE_NOP = 4'b1111;

    // BR_Type encodings.
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    // The register count as a 6-bit value, so 5-bit addresses compare without
    // truncation (REG_NUM may be 32).
    localparam logic [5:0] REG_LIM = 6'(REG_NUM);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Instruction fields.
    logic [5:0] opcode_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic [4:0] rd_s;

    assign opcode_s = instr_in[31:26];
    assign rs_s     = instr_in[25:21];
    assign rt_s     = instr_in[20:16];
    assign rd_s     = instr_in[15:11];

    // Controller outputs.
    logic       ctl_wb_en_s;
    logic       ctl_mem_r_en_s;
    logic       ctl_mem_w_en_s;
    logic       ctl_is_imm_s;
    logic [1:0] ctl_br_type_s;
    logic [3:0] ctl_exe_cmd_s;

    // Datapath signals.
    logic [DATA_W-1:0] rf_r [REG_NUM];
    logic              wb_legal_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] data2_s;
    logic [4:0]        dest_s;
    logic              rt_used_s;
    logic              exe_dest_live_s;
    logic              hazard_s;
    logic              load_s;

    // Controller: opcode decode into control bundle
    always_comb begin
        ctl_wb_en_s    = 1'b0;
        ctl_mem_r_en_s = 1'b0;
        ctl_mem_w_en_s = 1'b0;
        ctl_is_imm_s   = 1'b0;
        ctl_br_type_s  = BR_NONE;
        ctl_exe_cmd_s  = EXE_NOP;
        case (opcode_s)
            OP_NOP: begin
                ctl_exe_cmd_s = EXE_NOP;
            end
            OP_ADD: begin
                ctl_wb_en_s   = 1'b1;
                ctl_exe_cmd_s = EXE_ADD;
            end
            OP_SUB: begin
                ctl_wb_en_s   = 1'b1;
                ctl_exe_cmd_s = EXE_SUB;
            end
            OP_AND: begin
                ctl_wb_en_s   = 1'b1;
                ctl_exe_cmd_s = EXE_AND;
            end
            OP_OR: begin
                ctl_wb_en_s   = 1'b1;
                ctl_exe_cmd_s = EXE_OR;
            end
            OP_NOR: begin
                ctl_wb_en_s   = 1'b1;
                ctl_exe_cmd_s = EXE_NOR;
            end
            OP_XOR: begin
                ctl_wb_en_s   = 1'b1;
                ctl_exe_cmd_s = EXE_XOR;
            end
            OP_SLA, OP_SLL: begin
                ctl_wb_en_s   = 1'b1;
                ctl_exe_cmd_s = EXE_SLA;
            end
            OP_SRA: begin
                ctl_wb_en_s   = 1'b1;
                ctl_exe_cmd_s = EXE_SRA;
            end
            OP_SRL: begin
                ctl_wb_en_s   = 1'b1;
                ctl_exe_cmd_s = EXE_SRL;
            end
            OP_ADDI: begin
                ctl_wb_en_s   = 1'b1;
                ctl_is_imm_s  = 1'b1;
                ctl_exe_cmd_s = EXE_ADD;
            end
            OP_SUBI: begin
                ctl_wb_en_s   = 1'b1;
                ctl_is_imm_s  = 1'b1;
                ctl_exe_cmd_s = EXE_SUB;
            end
            OP_LD: begin
                ctl_wb_en_s    = 1'b1;
                ctl_mem_r_en_s = 1'b1;
                ctl_is_imm_s   = 1'b1;
                ctl_exe_cmd_s  = EXE_ADD;
            end
            OP_ST: begin
                ctl_mem_w_en_s = 1'b1;
                ctl_is_imm_s   = 1'b1;
                ctl_exe_cmd_s  = EXE_ADD;
            end
            OP_BEZ: begin
                ctl_is_imm_s  = 1'b1;
                ctl_br_type_s = BR_BEZ;
            end
            OP_BNE: begin
                ctl_is_imm_s  = 1'b1;
                ctl_br_type_s = BR_BNE;
            end
            OP_JMP: begin
                ctl_is_imm_s  = 1'b1;
                ctl_br_type_s = BR_JMP;
            end
            default: begin
                ctl_exe_cmd_s = EXE_NOP;
            end
        endcase
    end

    // A write is legal only for an existing register that is not the hardwired zero.
    assign wb_legal_s = wb_en && ({1'b0, wb_addr} < REG_LIM) &&
                        !((ZERO_REG != 0) && (wb_addr == 5'd0));

    // Register file storage with write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                rf_r[i] <= '0;
            end
        end else if (wb_legal_s) begin
            rf_r[wb_addr] <= wb_data;
        end
    end

    // Read port 1 (rs): zero/out-of-range handling, then bypass, then storage
    always_comb begin
        rd1_s = '0;
        if (({1'b0, rs_s} >= REG_LIM) || ((ZERO_REG != 0) && (rs_s == 5'd0))) begin
            rd1_s = '0;
        end else if ((BYPASS != 0) && wb_legal_s && (wb_addr == rs_s)) begin
            rd1_s = wb_data;
        end else begin
            rd1_s = rf_r[rs_s];
        end
    end

    // Read port 2 (rt): zero/out-of-range handling, then bypass, then storage
    always_comb begin
        rd2_s = '0;
        if (({1'b0, rt_s} >= REG_LIM) || ((ZERO_REG != 0) && (rt_s == 5'd0))) begin
            rd2_s = '0;
        end else if ((BYPASS != 0) && wb_legal_s && (wb_addr == rt_s)) begin
            rd2_s = wb_data;
        end else begin
            rd2_s = rf_r[rt_s];
        end
    end

    // Immediate extension, operand-2 select and destination select
    always_comb begin
        imm_s = '0;
        if (IMM_SIGNED != 0) begin
            imm_s = DATA_W'(signed'(instr_in[15:0]));
        end else begin
            imm_s = DATA_W'(instr_in[15:0]);
        end
        if (ctl_is_imm_s) begin
            data2_s = imm_s;
            dest_s  = rt_s;
        end else begin
            data2_s = rd2_s;
            dest_s  = rd_s;
        end
    end

    // Stores read rt as data even though they carry an immediate.
    assign rt_used_s = !ctl_is_imm_s || ctl_mem_w_en_s;

    // A load into the hardwired zero register can never create a dependency.
    assign exe_dest_live_s = !((ZERO_REG != 0) && (exe_dest == 5'd0));

    assign hazard_s = in_valid && exe_valid && exe_mem_r_en && exe_dest_live_s &&
                      ((exe_dest == rs_s) || (rt_used_s && (exe_dest == rt_s)));

    assign in_ready = !flush && !hazard_s && (!out_valid || out_ready);
    assign load_s   = in_valid && in_ready;

    // ID/EX pipeline register: flush > load > drain > hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_wb_en    <= 1'b0;
            out_mem_r_en <= 1'b0;
            out_mem_w_en <= 1'b0;
            out_br_type  <= 2'b00;
            out_exe_cmd  <= 4'b0000;
            out_rd1      <= '0;
            out_rd2      <= '0;
            out_imm      <= '0;
            out_data2    <= '0;
            out_dest     <= 5'd0;
            out_instr    <= 32'd0;
        end else if (flush) begin
            // Payload is kept; only the valid flag is dropped.
            out_valid <= 1'b0;
        end else if (load_s) begin
            out_valid    <= 1'b1;
            out_wb_en    <= ctl_wb_en_s;
            out_mem_r_en <= ctl_mem_r_en_s;
            out_mem_w_en <= ctl_mem_w_en_s;
            out_br_type  <= ctl_br_type_s;
            out_exe_cmd  <= ctl_exe_cmd_s;
            out_rd1      <= rd1_s;
            out_rd2      <= rd2_s;
            out_imm      <= imm_s;
            out_data2    <= data2_s;
            out_dest     <= dest_s;
            out_instr    <= instr_in;
        end else if (out_ready) begin
            // Consumed with nothing to replace it: a bubble during a hazard.
            out_valid <= 1'b0;
        end
    end

    // Saturating hazard-stall counter; flushed cycles are not counted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (hazard_s && !flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe. Instance a uses default parameters;
// instance b uses BYPASS=0, IMM_SIGNED=0, CNT_W=2 and shares every input.
module tb_id_stage_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr_in;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exe_valid;
    logic        exe_mem_r_en;
    logic [4:0]  exe_dest;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_wb_en, a_out_mem_r_en, a_out_mem_w_en;
    logic [1:0]  a_out_br_type;
    logic [3:0]  a_out_exe_cmd;
    logic [31:0] a_out_rd1, a_out_rd2, a_out_imm, a_out_data2, a_out_instr;
    logic [4:0]  a_out_dest;
    logic [15:0] a_stall_cnt;

    logic        b_in_ready, b_out_valid, b_out_wb_en, b_out_mem_r_en, b_out_mem_w_en;
    logic [1:0]  b_out_br_type;
    logic [3:0]  b_out_exe_cmd;
    logic [31:0] b_out_rd1, b_out_rd2, b_out_imm, b_out_data2, b_out_instr;
    logic [4:0]  b_out_dest;
    logic [1:0]  b_stall_cnt;

    int n_checks;
    int n_fail;

    id_stage_pipe dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .instr_in(instr_in), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .exe_valid(exe_valid), .exe_mem_r_en(exe_mem_r_en),
        .exe_dest(exe_dest), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_wb_en(a_out_wb_en), .out_mem_r_en(a_out_mem_r_en), .out_mem_w_en(a_out_mem_w_en),
        .out_br_type(a_out_br_type), .out_exe_cmd(a_out_exe_cmd), .out_rd1(a_out_rd1),
        .out_rd2(a_out_rd2), .out_imm(a_out_imm), .out_data2(a_out_data2),
        .out_dest(a_out_dest), .out_instr(a_out_instr), .stall_cnt(a_stall_cnt)
    );

    id_stage_pipe #(.BYPASS(0), .IMM_SIGNED(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .instr_in(instr_in), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .exe_valid(exe_valid), .exe_mem_r_en(exe_mem_r_en),
        .exe_dest(exe_dest), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_wb_en(b_out_wb_en), .out_mem_r_en(b_out_mem_r_en), .out_mem_w_en(b_out_mem_w_en),
        .out_br_type(b_out_br_type), .out_exe_cmd(b_out_exe_cmd), .out_rd1(b_out_rd1),
        .out_rd2(b_out_rd2), .out_imm(b_out_imm), .out_data2(b_out_data2),
        .out_dest(b_out_dest), .out_instr(b_out_instr), .stall_cnt(b_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", a_out_valid); end
        n_checks++; if (a_out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %0h want 0", a_out_instr); end
        n_checks++; if (a_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0h want 0", a_stall_cnt); end
        rst = 1'b1;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h want 1", a_in_ready); end
        step();
    endtask

    task automatic test_basic();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        step();
        wb_en = 1'b0;
        in_valid = 1'b1; instr_in = r_ins(6'd1, 5'd5, 5'd6, 5'd9);
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %0h want 1", a_in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0h want 1", a_out_valid); end
        n_checks++; if (a_out_rd1 !== 32'h1234) begin n_fail++; $display("FAIL basic_rd1: got %0h want 1234", a_out_rd1); end
        n_checks++; if (a_out_rd2 !== 32'h0) begin n_fail++; $display("FAIL basic_rd2: got %0h want 0", a_out_rd2); end
        n_checks++; if (a_out_dest !== 5'd9) begin n_fail++; $display("FAIL basic_dest: got %0h want 9", a_out_dest); end
        n_checks++; if (a_out_wb_en !== 1'b1) begin n_fail++; $display("FAIL basic_wb_en: got %0h want 1", a_out_wb_en); end
        n_checks++; if (a_out_exe_cmd !== 4'b0000) begin n_fail++; $display("FAIL basic_cmd: got %0h want 0", a_out_exe_cmd); end
        n_checks++; if (a_out_instr !== 32'h04A64800) begin n_fail++; $display("FAIL basic_instr: got %0h want 04a64800", a_out_instr); end
        step();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %0h want 0", a_out_valid); end
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1111;
        step();
        wb_data = 32'hCAFE;
        in_valid = 1'b1; instr_in = r_ins(6'd1, 5'd7, 5'd0, 5'd1);
        step();
        n_checks++; if (a_out_rd1 !== 32'hCAFE) begin n_fail++; $display("FAIL bypass_on: got %0h want cafe", a_out_rd1); end
        n_checks++; if (b_out_rd1 !== 32'h1111) begin n_fail++; $display("FAIL bypass_off: got %0h want 1111", b_out_rd1); end
        // A write to r0 must neither land nor be forwarded.
        wb_addr = 5'd0; wb_data = 32'hFFFF;
        instr_in = r_ins(6'd1, 5'd0, 5'd7, 5'd2);
        step();
        wb_en = 1'b0; in_valid = 1'b0;
        n_checks++; if (a_out_rd1 !== 32'h0) begin n_fail++; $display("FAIL zero_reg_read: got %0h want 0", a_out_rd1); end
        n_checks++; if (b_out_rd2 !== 32'hCAFE) begin n_fail++; $display("FAIL bypass_off_stored: got %0h want cafe", b_out_rd2); end
    endtask

    task automatic test_imm();
        in_valid = 1'b1; instr_in = i_ins(6'd32, 5'd0, 5'd4, 16'h8001);
        step();
        in_valid = 1'b0;
        n_checks++; if (a_out_imm !== 32'hFFFF8001) begin n_fail++; $display("FAIL imm_signed: got %0h want ffff8001", a_out_imm); end
        n_checks++; if (a_out_data2 !== 32'hFFFF8001) begin n_fail++; $display("FAIL data2_signed: got %0h want ffff8001", a_out_data2); end
        n_checks++; if (a_out_dest !== 5'd4) begin n_fail++; $display("FAIL imm_dest_a: got %0h want 4", a_out_dest); end
        n_checks++; if (b_out_imm !== 32'h00008001) begin n_fail++; $display("FAIL imm_zero: got %0h want 8001", b_out_imm); end
        n_checks++; if (b_out_data2 !== 32'h00008001) begin n_fail++; $display("FAIL data2_zero: got %0h want 8001", b_out_data2); end
        n_checks++; if (b_out_dest !== 5'd4) begin n_fail++; $display("FAIL imm_dest_b: got %0h want 4", b_out_dest); end
    endtask

    task automatic test_load_use();
        // Valid bundle in place, then a dependent instruction meets a load in EXE.
        in_valid = 1'b1; instr_in = r_ins(6'd1, 5'd5, 5'd6, 5'd8);
        step();
        exe_valid = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 5'd3;
        instr_in = r_ins(6'd1, 5'd3, 5'd1, 5'd2);
        #1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_ready0: got %0h want 0", a_in_ready); end
        step();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL hazard_bubble: got %0h want 0", a_out_valid); end
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_ready1: got %0h want 0", a_in_ready); end
        n_checks++; if (a_stall_cnt !== 16'd1) begin n_fail++; $display("FAIL hazard_cnt1: got %0h want 1", a_stall_cnt); end
        step();
        n_checks++; if (a_stall_cnt !== 16'd2) begin n_fail++; $display("FAIL hazard_cnt2: got %0h want 2", a_stall_cnt); end
        // Immediate ALU op does not read rt: no hazard on rt match.
        instr_in = i_ins(6'd32, 5'd1, 5'd3, 16'h0005);
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_rt_nohaz: got %0h want 1", a_in_ready); end
        // Store reads rt as data: hazard on rt match.
        instr_in = i_ins(6'd37, 5'd1, 5'd3, 16'h0000);
        #1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL st_rt_haz: got %0h want 0", a_in_ready); end
        exe_dest = 5'd0; instr_in = r_ins(6'd1, 5'd0, 5'd0, 5'd2);
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_dest_nohaz: got %0h want 1", a_in_ready); end
        step();
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL after_stall_load: got %0h want 1", a_out_valid); end
        n_checks++; if (a_stall_cnt !== 16'd2) begin n_fail++; $display("FAIL zero_dest_cnt: got %0h want 2", a_stall_cnt); end
        exe_valid = 1'b0; exe_mem_r_en = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; instr_in = r_ins(6'd3, 5'd5, 5'd7, 5'd11);
        step();
        out_ready = 1'b0; instr_in = r_ins(6'd1, 5'd5, 5'd5, 5'd12);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %0h want 0", i, a_in_ready); end
            n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0h want 1", i, a_out_valid); end
            n_checks++; if (a_out_instr !== 32'h0CA75800) begin n_fail++; $display("FAIL bp_instr[%0d]: got %0h want 0ca75800", i, a_out_instr); end
            n_checks++; if (a_out_rd2 !== 32'hCAFE) begin n_fail++; $display("FAIL bp_rd2[%0d]: got %0h want cafe", i, a_out_rd2); end
            n_checks++; if (a_out_exe_cmd !== 4'b0010) begin n_fail++; $display("FAIL bp_cmd[%0d]: got %0h want 2", i, a_out_exe_cmd); end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %0h want 1", a_in_ready); end
        step();
        n_checks++; if (a_out_dest !== 5'd12) begin n_fail++; $display("FAIL bp_next_dest: got %0h want 12", a_out_dest); end
        n_checks++; if (a_out_rd2 !== 32'h1234) begin n_fail++; $display("FAIL bp_next_rd2: got %0h want 1234", a_out_rd2); end
    endtask

    task automatic test_flush();
        flush = 1'b1; in_valid = 1'b1; instr_in = r_ins(6'd1, 5'd5, 5'd0, 5'd13);
        exe_valid = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 5'd5;
        #1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0h want 0", a_in_ready); end
        step();
        flush = 1'b0;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0h want 0", a_out_valid); end
        n_checks++; if (a_out_instr !== 32'h04A56000) begin n_fail++; $display("FAIL flush_payload: got %0h want 04a56000", a_out_instr); end
        n_checks++; if (a_stall_cnt !== 16'd2) begin n_fail++; $display("FAIL flush_cnt: got %0h want 2", a_stall_cnt); end
    endtask

    task automatic test_saturate();
        // Hazard inputs still applied from the flush scenario.
        for (int i = 0; i < 3; i++) step();
        n_checks++; if (a_stall_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_cnt_a: got %0h want 5", a_stall_cnt); end
        n_checks++; if (b_stall_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_cnt_b: got %0h want 3", b_stall_cnt); end
        exe_valid = 1'b0; exe_mem_r_en = 1'b0;
    endtask

    task automatic test_async_reset();
        instr_in = r_ins(6'd1, 5'd5, 5'd7, 5'd14);
        step();
        n_checks++; if (a_out_rd1 !== 32'h1234) begin n_fail++; $display("FAIL pre_rst_rd1: got %0h want 1234", a_out_rd1); end
        out_ready = 1'b0; exe_valid = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 5'd5;
        step();
        #2 rst = 1'b0;
        #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0h want 0", a_out_valid); end
        n_checks++; if (a_out_instr !== 32'd0) begin n_fail++; $display("FAIL arst_instr: got %0h want 0", a_out_instr); end
        n_checks++; if (a_out_rd1 !== 32'd0) begin n_fail++; $display("FAIL arst_rd1: got %0h want 0", a_out_rd1); end
        n_checks++; if (a_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_cnt: got %0h want 0", a_stall_cnt); end
        rst = 1'b1; out_ready = 1'b1; exe_valid = 1'b0; exe_mem_r_en = 1'b0;
        instr_in = r_ins(6'd1, 5'd5, 5'd7, 5'd15);
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %0h want 1", a_in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_reload: got %0h want 1", a_out_valid); end
        n_checks++; if (a_out_rd1 !== 32'd0) begin n_fail++; $display("FAIL arst_r5: got %0h want 0", a_out_rd1); end
        n_checks++; if (a_out_rd2 !== 32'd0) begin n_fail++; $display("FAIL arst_r7: got %0h want 0", a_out_rd2); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b0; in_valid = 1'b0; instr_in = 32'd0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        exe_valid = 1'b0; exe_mem_r_en = 1'b0; exe_dest = 5'd0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_bypass();
        test_imm();
        test_load_use();
        test_backpressure();
        test_flush();
        test_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised next-generation instruction-decode stage with an integrated ID/EX pipeline register.
- Decodes a 32-bit MIPS-style instruction using the existing Controller, reads a REG_NUM x DATA_W register file with write-back bypass, extends the immediate and selects operand 2.
- Detects load-use hazards against the EXE stage and presents registered results under a valid/ready handshake, with flush and a stall counter.

Parameters:
DATA_W, 32, register/operand width; legal range 16..64.
REG_NUM, 32, number of architectural registers; legal range 2..32; addresses use instr[25:21]/[20:16]/[15:11].
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes.
BYPASS, 1, 1 = same-cycle write-back data forwarded to read ports.
IMM_SIGNED, 1, 1 = sign-extend instr[15:0] to DATA_W; 0 = zero-extend.
CNT_W, 16, width of the stall counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-low reset.
in_valid  in  1  instr_in is valid.
in_ready  out  1  stage accepts instr_in this cycle.
instr_in  in  32  instruction from IF.
flush  in  1  discard the held entry and the current input.
wb_en  in  1  register write enable.
wb_addr  in  5  write address.
wb_data  in  DATA_W  write data.
exe_valid  in  1  EXE stage holds a valid instruction.
exe_mem_r_en  in  1  EXE instruction is a load.
exe_dest  in  5  EXE destination register.
out_valid  out  1  output bundle valid.
out_ready  in  1  EXE accepts the bundle.
out_wb_en, out_mem_r_en, out_mem_w_en  out  1 each  registered Controller outputs.
out_br_type  out  2  registered BR_Type.
out_exe_cmd  out  4  registered EXE_Cmd.
out_rd1, out_rd2  out  DATA_W  registered read data.
out_imm  out  DATA_W  registered extended immediate.
out_data2  out  DATA_W  Is_Imm ? imm : rd2, registered.
out_dest  out  5  Is_Imm ? instr[20:16] : instr[15:11], registered.
out_instr  out  32  registered instruction.
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (rst=0, asynchronous): all register-file entries, every output register and stall_cnt go to 0; out_valid=0. in_ready is combinational and equals 1 after reset if no hazard/flush.
- Register file write: at posedge when wb_en=1, wb_addr<REG_NUM, and not (ZERO_REG and wb_addr==0). All other writes are ignored.
- Register file read: combinational.
  - Address >= REG_NUM reads 0.
  - Address 0 reads 0 when ZERO_REG=1.
  - If BYPASS=1, wb_en=1, wb_addr==read address and the write is legal, the read returns wb_data.
  - Otherwise the read returns stored data.
- rt_used = !Is_Imm | MEM_W_En.
- hazard = in_valid & exe_valid & exe_mem_r_en & !(ZERO_REG & exe_dest==0) & (exe_dest==instr[25:21] | (rt_used & exe_dest==instr[20:16])).
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Load: in_valid & in_ready. At the edge, all out_* registers capture the decoded values and out_valid<=1.
- Priority at each edge:
  1. flush: out_valid<=0, payload unchanged.
  2. load.
  3. out_ready: out_valid<=0, which inserts a bubble during a hazard.
  4. Otherwise hold every output unchanged.
- Output stability: while out_valid=1 and out_ready=0, the bundle must not change.
- Latency: 1 cycle from acceptance to out_valid.
- Full throughput: one instruction per cycle when out_ready=1 and there is no hazard.
- stall_cnt increments on each edge where hazard=1 and flush=0; it saturates at 2^CNT_W-1 and resets only on rst.
- Simultaneous write-back and read of the same register in the accepting cycle: the captured rd value is wb_data when BYPASS=1, and the old value otherwise.
- Reset asserted mid-stall: clears immediately. No pending state survives.

Test Plan:
- Reset then write r5=0x1234 (wb_en one cycle). Then accept instr with rs=5, rt=6, R-type, out_ready=1 → next cycle out_valid=1, out_rd1=0x1234, out_rd2=0, out_dest=instr[15:11].
- Bypass: wb_en=1, wb_addr=7, wb_data=0xCAFE in the same cycle an instruction with rs=7 is accepted → out_rd1=0xCAFE (BYPASS=1). Same stimulus with BYPASS=0 → out_rd1=old r7.
- Immediate: instr[15:0]=0x8001 I-type → out_imm=0xFFFF8001 and out_data2=out_imm with IMM_SIGNED=1. With IMM_SIGNED=0 → out_imm=0x00008001. In both cases out_dest=instr[20:16].
- Load-use: exe_valid=1, exe_mem_r_en=1, exe_dest=3, incoming rs=3 for 2 cycles → in_ready=0 for 2 cycles, a bubble (out_valid=0) after the drain, stall_cnt=2. With exe_dest=0 and ZERO_REG=1 → no stall.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → in_ready=0 and the bundle is constant. When out_ready returns to 1, the next instruction loads on that edge.
- Flush with out_valid=1 and in_valid=1 → next cycle out_valid=0, in_ready=0 during flush, stall_cnt unchanged. Async rst pulse mid-stream → all outputs 0 immediately and r5 reads 0.
